mdu: RTL and testbench
======================

# mdu

Parametrised iterative multiply/divide unit that executes the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and their RV64 word forms. It sits in the execute stage beside the combinational integer ALU. Operations take multiple cycles, so the unit uses a valid/ready request/response handshake and supports a pipeline flush.

## Interface
- `n`, default 64: operand and result width (XLEN). Legal values: 32 or 64.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill. Aborts any in-flight or held operation.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_op` input 3: operation, RISC-V funct3 encoding (MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7).
- `req_is_word` input 1: word form (MULW/DIVW/DIVUW/REMW/REMUW). Only meaningful when `n`=64.
- `req_src_1` input n: dividend or multiplicand.
- `req_src_2` input n: divisor or multiplier.
- `resp_valid` output 1: result present.
- `resp_ready` input 1: consumer accepts the result.
- `resp_result` output n: result.
- `busy` output 1: the unit is in CALC or DONE.

## Operation
- State machine: IDLE → CALC → DONE → IDLE.
  - IDLE: `req_ready`=1. A request is accepted on `req_valid && req_ready`.
  - On acceptance, the operands are latched and transformed as follows:
    - Signed operands are converted to magnitudes, and the result sign is recorded.
    - MULHSU treats `src_1` as signed and `src_2` as unsigned.
    - Word forms use bits [31:0] only.
  - Special cases go straight to DONE with the result computed at acceptance:
    - Divide by zero: quotient = all ones; remainder = dividend (sign-extended for word forms).
    - Signed overflow (most-negative / -1): quotient = most-negative; remainder = 0.
  - CALC iterations:
    - Multiply is radix-2 shift-add into a 2n-bit accumulator.
    - Divide is restoring division, one quotient bit per step.
    - Iteration count is `n` (32 for word forms).
    - The final step applies sign correction and selects the result: low half for MUL, high half for MULH*, quotient or remainder for divides.
  - DONE: `resp_valid`=1 and `resp_result` holds stable until `resp_ready`. On `resp_valid && resp_ready`, the unit returns to IDLE.
- Word forms sign-extend the 32-bit result to `n`.
- MULH/MULHSU/MULHU with `req_is_word`=1 are illegal and return 0 with minimal latency.
- Signed remainder takes the dividend's sign. Signed quotient is truncated toward zero.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_result`=0, `busy`=0.
- `req_ready` is low from the cycle after acceptance until the cycle after the response handshake. No new request is accepted in the handshake cycle.
- Latency from acceptance edge to `resp_valid` high:
  - Normal operations: `n`+1 cycles (33 for word forms).
  - Special and illegal cases: 1 cycle.
- `flush`:
  - Highest priority, above reset-free transitions and handshakes.
  - Next state is IDLE, `resp_valid` falls next cycle, and the pending result is discarded.
  - A request presented in the same cycle as `flush` is not accepted.
- Reset asserted mid-CALC or mid-DONE forces all outputs to their reset values immediately.
- All outputs are registered. There is no combinational path from `req_*` to `resp_*`.

## Configuration
- `MDU_RADIX4_EN`:
  - Defined: two iteration steps per CALC cycle. Normal latency becomes `n`/2+1 (17 for word forms).
  - Undefined: one step per cycle, latencies as in Timing.
  - Special-case latency and the handshake are unchanged either way.

## Structure
- `mdu_pkg` contains:
  - Op enum (funct3 values).
  - State enum.
  - Constants: `MDU_STEPS_PER_CYCLE` (1 or 2 per macro) and the word width 32.
- Sub-module `mdu_div_step`: one combinational restoring-divide step (partial remainder, divisor → next remainder and quotient bit). Instantiated once, or chained twice under `MDU_RADIX4_EN`.

## Test plan
- MUL 7 × 0xFFFF_FFFF_FFFF_FFFD (n=64) → 0xFFFF_FFFF_FFFF_FFEB, with `resp_valid` 65 cycles after acceptance (33 with `MDU_RADIX4_EN`). MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE.
- DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD. REM −7 / 2 → 0xFFFF_FFFF_FFFF_FFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → all ones and REM 5 / 0 → 5, each with `resp_valid` 1 cycle after acceptance. DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000, and the matching REM → 0.
- Word forms:
  - DIVW with `src_1`=0x0000_0001_8000_0000, `src_2`=1 → 0xFFFF_FFFF_8000_0000.
  - MULW 0x7FFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
  - MULH with `req_is_word`=1 → 0.
- Backpressure: hold `resp_ready`=0 for 5 cycles in DONE → `resp_result` stable, `req_ready`=0 throughout. After the handshake, `req_ready`=1 the next cycle.
- Abort: `flush` at CALC cycle 10 → IDLE and `req_ready`=1 next cycle, with no `resp_valid`. `rst_n` low mid-DONE → `resp_valid`=0 and `resp_result`=0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the iterative multiply/divide
//               unit. MDU_RADIX4_EN selects two iteration steps per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation codes follow the RISC-V M-extension funct3 field
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

`ifdef MDU_RADIX4_EN
    localparam int MDU_STEPS_PER_CYCLE = 2;
`else
    localparam int MDU_STEPS_PER_CYCLE = 1;
`endif

    localparam int MDU_WORD_W = 32;

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_step
// Description : One combinational restoring-division step: shifts the next
//               dividend bit into the partial remainder and subtracts the
//               divisor when it fits.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
    parameter int n = 64
) (
    input  logic [n-1:0] i_rem,
    input  logic         i_dvd_bit,
    input  logic [n-1:0] i_divisor,
    output logic [n-1:0] o_rem,
    output logic         o_q_bit
);

    logic [n:0] w_trial;
    logic [n:0] w_diff;

    // Remainder stays below the divisor, so bit n of the difference is the borrow
    assign w_trial = {i_rem, i_dvd_bit};
    assign w_diff  = w_trial - {1'b0, i_divisor};
    assign o_q_bit = ~w_diff[n];
    assign o_rem   = o_q_bit ? w_diff[n-1:0] : w_trial[n-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Iterative RISC-V M-extension multiply/divide unit with
//               valid/ready handshakes and flush. Defining MDU_RADIX4_EN
//               (see mdu_pkg) doubles the iteration steps per CALC cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mdu_pkg::*;
#(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic         req_is_word,
    input  logic [n-1:0] req_src_1,
    input  logic [n-1:0] req_src_2,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [n-1:0] resp_result,
    output logic         busy
);

    localparam int            CNT_W        = 8;
    localparam int            c_word_shift = n - MDU_WORD_W;
    localparam logic [n-1:0]  c_lo_mask    = {n{1'b1}} >> c_word_shift;
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(n / MDU_STEPS_PER_CYCLE);
    localparam logic [CNT_W-1:0] c_cnt_word = CNT_W'(MDU_WORD_W / MDU_STEPS_PER_CYCLE);

    function automatic logic [n-1:0] sext_word(input logic [n-1:0] x);
        return x[MDU_WORD_W-1] ? (x | ~c_lo_mask) : (x & c_lo_mask);
    endfunction

    mdu_state_e     state_q, state_d;
    mdu_op_e        op_q, op_d;
    logic [2*n-1:0] acc_q, acc_d;
    logic [n-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           word_q, word_d, neg_q, neg_d;
    logic           req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, busy_q, busy_d;
    logic [n-1:0]   resp_result_q, resp_result_d;

    // Acceptance-time decode: effective operand values, magnitudes, special cases
    logic         w_word, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg;
    logic         w_illegal, w_b_zero, w_ovf, w_special;
    logic [n-1:0] w_a_val, w_b_val, w_a_mag, w_b_mag, w_min, w_special_res;

    // Decode the incoming request into magnitudes, result sign and special results
    always_comb begin
        w_word     = req_is_word && (n > MDU_WORD_W);
        w_is_div   = req_op[2];
        w_a_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                     (req_op == OP_DIV)  || (req_op == OP_REM);
        w_b_signed = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        w_a_val    = w_word ? (w_a_signed ? sext_word(req_src_1) : (req_src_1 & c_lo_mask)) : req_src_1;
        w_b_val    = w_word ? (w_b_signed ? sext_word(req_src_2) : (req_src_2 & c_lo_mask)) : req_src_2;
        w_a_neg    = w_a_signed && w_a_val[n-1];
        w_b_neg    = w_b_signed && w_b_val[n-1];
        w_a_mag    = w_a_neg ? -w_a_val : w_a_val;
        w_b_mag    = w_b_neg ? -w_b_val : w_b_val;
        // Remainder follows the dividend sign; everything else uses the XOR
        w_neg      = (req_op == OP_REM || req_op == OP_REMU) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_min      = ~(w_word ? (c_lo_mask >> 1) : ({n{1'b1}} >> 1));
        w_illegal  = w_word && !w_is_div && (req_op != OP_MUL);
        w_b_zero   = (w_b_val == '0);
        w_ovf      = (req_op == OP_DIV || req_op == OP_REM) && (w_a_val == w_min) && (w_b_val == '1);
        w_special  = w_illegal || (w_is_div && w_b_zero) || w_ovf;
        if (w_illegal)
            w_special_res = '0;
        else if (w_is_div && w_b_zero)
            w_special_res = (req_op == OP_DIV || req_op == OP_DIVU) ? '1
                          : (w_word ? sext_word(req_src_1) : req_src_1);
        else if (w_ovf)
            w_special_res = (req_op == OP_DIV) ? w_min : '0;
        else
            w_special_res = '0;
    end

    // Shift-add multiply, multiplier consumed MSB first
    logic [2*n-1:0] w_mul_acc;
    logic [n-1:0]   w_mul_b;
    always_comb begin
        w_mul_acc = acc_q;
        w_mul_b   = opb_q;
        for (int i = 0; i < MDU_STEPS_PER_CYCLE; i++) begin
            w_mul_acc = {w_mul_acc[2*n-2:0], 1'b0} +
                        ({{n{1'b0}}, opa_q} & {(2*n){w_mul_b[n-1]}});
            w_mul_b   = {w_mul_b[n-2:0], 1'b0};
        end
    end

    // Restoring divide: remainder in the upper half, dividend/quotient in the lower
    logic [n-1:0] w_rem_1, w_dvd_1, w_rem_last, w_dvd_last;
    logic         w_qbit_1;

    mdu_div_step #(.n(n)) u_div_step_0 (
        .i_rem     (acc_q[2*n-1:n]),
        .i_dvd_bit (acc_q[n-1]),
        .i_divisor (opa_q),
        .o_rem     (w_rem_1),
        .o_q_bit   (w_qbit_1)
    );
    assign w_dvd_1 = {acc_q[n-2:0], w_qbit_1};

    if (MDU_STEPS_PER_CYCLE == 2) begin : g_radix4
        logic w_qbit_2;
        mdu_div_step #(.n(n)) u_div_step_1 (
            .i_rem     (w_rem_1),
            .i_dvd_bit (w_dvd_1[n-1]),
            .i_divisor (opa_q),
            .o_rem     (w_rem_last),
            .o_q_bit   (w_qbit_2)
        );
        assign w_dvd_last = {w_dvd_1[n-2:0], w_qbit_2};
    end else begin : g_radix2
        assign w_rem_last = w_rem_1;
        assign w_dvd_last = w_dvd_1;
    end

    // Step result plus sign correction and result selection for the last step
    logic           w_op_div;
    logic [2*n-1:0] w_step_acc, w_prod;
    logic [n-1:0]   w_div_mag, w_div_res, w_final;
    always_comb begin
        w_op_div   = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_REM) || (op_q == OP_REMU);
        w_step_acc = w_op_div ? {w_rem_last, w_dvd_last} : w_mul_acc;
        w_prod     = neg_q ? -w_step_acc : w_step_acc;
        w_div_mag  = (op_q == OP_REM || op_q == OP_REMU) ? w_step_acc[2*n-1:n] : w_step_acc[n-1:0];
        w_div_res  = neg_q ? -w_div_mag : w_div_mag;
        if (w_op_div)
            w_final = word_q ? sext_word(w_div_res) : w_div_res;
        else if (op_q == OP_MUL)
            w_final = word_q ? sext_word(w_prod[n-1:0]) : w_prod[n-1:0];
        else
            w_final = w_prod[2*n-1:n];
    end

    // Next-state and registered-output logic; flush overrides everything
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        acc_d         = acc_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        neg_d         = neg_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        busy_d        = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = mdu_op_e'(req_op);
                    word_d      = w_word;
                    neg_d       = w_neg;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (w_special) begin
                        state_d       = ST_DONE;
                        resp_valid_d  = 1'b1;
                        resp_result_d = w_special_res;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = w_word ? c_cnt_word : c_cnt_full;
                        if (w_is_div) begin
                            opa_d = w_b_mag;
                            opb_d = '0;
                            acc_d = {{n{1'b0}}, (w_word ? (w_a_mag << c_word_shift) : w_a_mag)};
                        end else begin
                            opa_d = w_a_mag;
                            opb_d = w_word ? (w_b_mag << c_word_shift) : w_b_mag;
                            acc_d = '0;
                        end
                    end
                end
            end
            ST_CALC: begin
                acc_d = w_step_acc;
                opb_d = w_mul_b;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d       = ST_DONE;
                    resp_valid_d  = 1'b1;
                    resp_result_d = w_final;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
            busy_d       = 1'b0;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_MUL;
            acc_q         <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            cnt_q         <= '0;
            word_q        <= 1'b0;
            neg_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            acc_q         <= acc_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            neg_q         <= neg_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Directed self-checking bench for mdu (n=64) with an
//               expected-result queue. Honours MDU_RADIX4_EN for latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam int N = 64;
`ifdef MDU_RADIX4_EN
    localparam int LAT_D = 33;
    localparam int LAT_W = 17;
`else
    localparam int LAT_D = 65;
    localparam int LAT_W = 33;
`endif
    localparam int LAT_S = 1;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam logic [N-1:0] ONES = {N{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_is_word = 1'b0;
    logic         resp_ready = 1'b0;
    logic [2:0]   req_op = 3'd0;
    logic [N-1:0] req_src_1 = '0;
    logic [N-1:0] req_src_2 = '0;
    logic         req_ready, resp_valid, busy;
    logic [N-1:0] resp_result;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    mdu #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_is_word (req_is_word),
        .req_src_1   (req_src_1),
        .req_src_2   (req_src_2),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request; returns 1 time unit after the acceptance edge
    task automatic send(input string tag, input logic [2:0] op, input logic w,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp, input bit track);
        @(negedge clk);
        check({tag, "_req_ready"}, N'(req_ready), N'(1));
        req_valid   = 1'b1;
        req_op      = op;
        req_is_word = w;
        req_src_1   = a;
        req_src_2   = b;
        if (track) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for the response, check latency/result, hold for `hold` cycles, then handshake
    task automatic receive(input string tag, input int lat, input int hold);
        int cyc;
        logic [N-1:0] exp;
        cyc = 1;
        check({tag, "_busy_ready"}, N'(req_ready), N'(0));
        while (resp_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, N'(cyc), N'(lat));
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check({tag, "_result"}, resp_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_result"}, resp_result, exp);
            check({tag, "_hold_ready"}, N'({req_ready, resp_valid}), N'(2'b01));
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_after_hs"}, N'({req_ready, resp_valid, busy}), N'(3'b100));
    endtask

    initial begin
        int seen;
        // Reset values
        #12;
        check("reset_outputs", N'({req_ready, resp_valid, busy}), N'(3'b100));
        check("reset_result", resp_result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        send("mul", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        receive("mul", LAT_D, 0);
        send("mulhu", MULHU, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        receive("mulhu", LAT_D, 0);
        send("mulh", MULH, 1'b0, ONES, ONES, 64'd0, 1'b1);
        receive("mulh", LAT_D, 0);
        send("mulhsu", MULHSU, 1'b0, ONES, 64'd2, ONES, 1'b1);
        receive("mulhsu", LAT_D, 0);
        send("div", DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        receive("div", LAT_D, 0);
        send("rem", REM, 1'b0, -64'sd7, 64'd2, ONES, 1'b1);
        receive("rem", LAT_D, 0);
        send("divu", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1);
        receive("divu", LAT_D, 0);
        send("remu_bp", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 1'b1);
        receive("remu_bp", LAT_D, 5);

        // Special cases
        send("divu_by0", DIVU, 1'b0, 64'd5, 64'd0, ONES, 1'b1);
        receive("divu_by0", LAT_S, 0);
        send("rem_by0", REM, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1);
        receive("rem_by0", LAT_S, 0);
        send("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1'b1);
        receive("div_ovf", LAT_S, 0);
        send("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1'b1);
        receive("rem_ovf", LAT_S, 0);

        // Word forms
        send("divw", DIV, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b1);
        receive("divw", LAT_W, 0);
        send("mulw", MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        receive("mulw", LAT_W, 0);
        send("remw", REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, ONES, 1'b1);
        receive("remw", LAT_W, 0);
        send("divuw", DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b1);
        receive("divuw", LAT_W, 0);
        send("mulhw_illegal", MULH, 1'b1, ONES, 64'd3, 64'd0, 1'b1);
        receive("mulhw_illegal", LAT_S, 0);

        // Flush at CALC cycle 10, with a competing request in the same cycle
        send("flush_op", DIVU, 1'b0, 64'd1000, 64'd3, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush       = 1'b1;
        req_valid   = 1'b1;
        req_op      = DIVU;
        req_is_word = 1'b0;
        req_src_1   = 64'd9;
        req_src_2   = 64'd0;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_state", N'({req_ready, resp_valid, busy}), N'(3'b100));
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) seen++;
        end
        check("flush_no_resp", N'(seen), N'(0));
        send("post_flush", REMU, 1'b0, 64'd23, 64'd5, 64'd3, 1'b1);
        receive("post_flush", LAT_D, 0);

        // Asynchronous reset while holding a result in DONE
        send("rst_op", DIVU, 1'b0, 64'd5, 64'd0, ONES, 1'b0);
        check("rst_pre_valid", N'(resp_valid), N'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", N'({req_ready, resp_valid, busy}), N'(3'b100));
        check("rst_mid_result", resp_result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        send("post_rst", MUL, 1'b0, 64'd12345, 64'd1000, 64'd12345000, 1'b1);
        receive("post_rst", LAT_D, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
